rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4 (range 1-7): consecutive cycles a pending multi-cycle write may lose arbitration before the pipeline is stalled.
REQ-002 SHALL have port clk, input, 1, the single clock for the block.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pipe_we_i, input, 1, pipeline WB-stage write request.
REQ-005 SHALL have port pipe_waddr_i, input, 5, pipeline destination register.
REQ-006 SHALL have port pipe_wdata_i, input, 32, pipeline write data.
REQ-007 SHALL have port mc_valid_i, input, 1, multi-cycle unit (div/CSR/LSU) write offer.
REQ-008 SHALL have port mc_waddr_i, input, 5, multi-cycle destination register.
REQ-009 SHALL have port mc_wdata_i, input, 32, multi-cycle write data.
REQ-010 SHALL have port mc_ready_o, output, 1, arbiter can accept a multi-cycle write this cycle.
REQ-011 SHALL have port pipe_stall_o, output, 1, pipeline must hold its WB stage this cycle.
REQ-012 SHALL have port reg_we_o, output, 1, register-file write enable (registered).
REQ-013 SHALL have port reg_waddr_o, output, 5, register-file write address (registered).
REQ-014 SHALL have port reg_wdata_o, output, 32, register-file write data (registered).
REQ-015 SHALL have port fifo_cnt_o, output, 2, pending multi-cycle entries (0-2).

Function
REQ-016 SHALL hold multi-cycle writes in a 2-entry in-order FIFO; mc_ready_o = (count < 2), derived from registered state only, no path from pipe_* inputs.
REQ-017 SHALL accept when mc_valid_i && mc_ready_o; accepted writes with mc_waddr_i = 0 are discarded, not enqueued.
REQ-018 SHALL not accept when full even if the head is dequeued the same cycle.
REQ-019 SHALL make an accepted entry eligible for grant no earlier than the cycle after acceptance (no bypass).
REQ-020 SHALL treat a pipeline request as valid only when pipe_we_i = 1 and pipe_waddr_i != 0; an x0 pipeline write consumes no port.
REQ-021 SHALL grant per cycle with priority: (a) pipe_stall_o = 1 and FIFO non-empty -> FIFO head; (b) valid pipeline request -> pipeline; (c) FIFO non-empty -> FIFO head; (d) none.
REQ-022 SHALL keep a 3-bit saturating age counter: increments each cycle the FIFO is non-empty and the head is not granted; clears when the head is granted or the FIFO is empty.
REQ-023 SHALL drive pipe_stall_o = (age >= STARVE_LIMIT) && FIFO non-empty, combinationally from registered state.
REQ-024 SHALL, when pipe_stall_o = 1, ignore pipe_* that cycle; the stalled pipeline re-presents its write the following cycle.
REQ-025 SHALL register the winner: next cycle reg_we_o = 1 with its address and data; with no grant, reg_we_o = 0, reg_waddr_o = 0, reg_wdata_o = 0.
REQ-026 SHALL give latency of exactly 1 cycle from grant to reg_we_o.
REQ-027 SHALL handle simultaneous enqueue and dequeue when count = 1: count stays 1, FIFO order preserved.
REQ-028 SHALL never issue more than one register-file write per cycle and never drop a valid pipeline request except under REQ-024.

Reset
REQ-029 SHALL, while rst = 0, asynchronously clear FIFO (count 0), age 0, reg_we_o 0, reg_waddr_o 0, reg_wdata_o 0; hence mc_ready_o = 1 and pipe_stall_o = 0.
REQ-030 SHALL discard pending FIFO entries on reset asserted mid-operation; no write is issued after release until a new grant.

Verification
REQ-031 SHALL verify: idle, pipe_we_i=1, waddr=5, wdata=0xA5A5A5A5 -> next cycle reg_we_o=1, waddr 5, data 0xA5A5A5A5.
REQ-032 SHALL verify: mc offer x7=0x11 with pipeline idle -> enqueued, written two cycles after acceptance; fifo_cnt_o 1 then 0.
REQ-033 SHALL verify: two mc offers back-to-back while pipeline writes every cycle -> mc_ready_o=0 at count 2; third offer held until space.
REQ-034 SHALL verify: continuous pipeline writes with one pending mc entry, STARVE_LIMIT=4 -> pipe_stall_o=1 on 5th pending cycle, head written next cycle, stall drops.
REQ-035 SHALL verify: pipe write to x0 and mc write to x3 pending same cycle -> x3 granted; mc offer to x0 -> no enqueue, no write.
REQ-036 SHALL verify: rst=0 asserted with count=2 and reg_we_o=1 -> all outputs 0 immediately, mc_ready_o=1, no stale write after release.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
//    Arbitrates the single register-file write port between the pipeline
//    WB stage and a 2-entry in-order FIFO of multi-cycle unit writes
//    (divider, CSR, LSU). The pipeline normally has priority. A FIFO head
//    that loses arbitration for STARVE_LIMIT consecutive cycles stalls the
//    pipeline, and the head is then written.
//
// Ports
//    clk           clock
//    rst           asynchronous active-low reset
//    pipe_we_i     pipeline WB write request
//    pipe_waddr_i  pipeline destination register
//    pipe_wdata_i  pipeline write data
//    mc_valid_i    multi-cycle unit write offer
//    mc_waddr_i    multi-cycle destination register
//    mc_wdata_i    multi-cycle write data
//    mc_ready_o    a multi-cycle write can be accepted this cycle
//    pipe_stall_o  pipeline must hold its WB stage this cycle
//    reg_we_o      register-file write enable (registered)
//    reg_waddr_o   register-file write address (registered)
//    reg_wdata_o   register-file write data (registered)
//    fifo_cnt_o    number of pending multi-cycle entries (0-2)
module rf_wr_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we_i,
   input  logic [4:0]  pipe_waddr_i,
   input  logic [31:0] pipe_wdata_i,
   input  logic        mc_valid_i,
   input  logic [4:0]  mc_waddr_i,
   input  logic [31:0] mc_wdata_i,
   output logic        mc_ready_o,
   output logic        pipe_stall_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o,
   output logic [1:0]  fifo_cnt_o
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_FIFO = 2'd2
   } gnt_e;

   logic [4:0]  addr_q [2];
   logic [31:0] data_q [2];
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic [2:0]  age_q;

   logic        fifo_nempty;
   logic        accept;
   logic        enq;
   logic        deq;
   logic        wr_idx;
   logic        pipe_valid;
   gnt_e        gnt;

   assign fifo_nempty  = (count_q != 2'd0);
   // Both outputs depend only on registered state: no pipe_* to mc_ready_o path.
   assign mc_ready_o   = (count_q != 2'd2);
   assign pipe_stall_o = (age_q >= 3'(STARVE_LIMIT)) && fifo_nempty;
   assign fifo_cnt_o   = count_q;

   assign accept = mc_valid_i && mc_ready_o;
   // Writes to x0 are acknowledged but never take a FIFO slot.
   assign enq    = accept && (mc_waddr_i != 5'd0);
   // Free slot sits right after the head; valid even when the head leaves this cycle.
   assign wr_idx = rd_ptr_q ^ count_q[0];

   // A stalled pipeline re-presents its write next cycle, so it is ignored here.
   assign pipe_valid = pipe_we_i && (pipe_waddr_i != 5'd0) && !pipe_stall_o;

   always_comb begin
      gnt = GNT_NONE;
      if (pipe_stall_o)
         gnt = GNT_FIFO;
      else if (pipe_valid)
         gnt = GNT_PIPE;
      else if (fifo_nempty)
         gnt = GNT_FIFO;
   end

   assign deq = (gnt == GNT_FIFO);

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_idx] <= mc_waddr_i;
         data_q[wr_idx] <= mc_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
         age_q       <= '0;
         reg_we_o    <= 1'b0;
         reg_waddr_o <= '0;
         reg_wdata_o <= '0;
      end else begin
         if (deq)
            rd_ptr_q <= ~rd_ptr_q;
         case ({enq, deq})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase

         if (!fifo_nempty || deq)
            age_q <= '0;
         else if (age_q != 3'd7)
            age_q <= age_q + 3'd1;

         case (gnt)
            GNT_PIPE: begin
               reg_we_o    <= 1'b1;
               reg_waddr_o <= pipe_waddr_i;
               reg_wdata_o <= pipe_wdata_i;
            end
            GNT_FIFO: begin
               reg_we_o    <= 1'b1;
               reg_waddr_o <= addr_q[rd_ptr_q];
               reg_wdata_o <= data_q[rd_ptr_q];
            end
            default: begin
               reg_we_o    <= 1'b0;
               reg_waddr_o <= '0;
               reg_wdata_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter
//    Directed bench for rf_wr_arbiter (STARVE_LIMIT = 4). Inputs change
//    1 time unit after each rising edge; outputs are checked at that point.
module tb_rf_wr_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_we_i;
   logic [4:0]  pipe_waddr_i;
   logic [31:0] pipe_wdata_i;
   logic        mc_valid_i;
   logic [4:0]  mc_waddr_i;
   logic [31:0] mc_wdata_i;
   logic        mc_ready_o;
   logic        pipe_stall_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic [1:0]  fifo_cnt_o;

   int checks = 0;
   int errors = 0;

   rf_wr_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_we_i    (pipe_we_i),
      .pipe_waddr_i (pipe_waddr_i),
      .pipe_wdata_i (pipe_wdata_i),
      .mc_valid_i   (mc_valid_i),
      .mc_waddr_i   (mc_waddr_i),
      .mc_wdata_i   (mc_wdata_i),
      .mc_ready_o   (mc_ready_o),
      .pipe_stall_o (pipe_stall_o),
      .reg_we_o     (reg_we_o),
      .reg_waddr_o  (reg_waddr_o),
      .reg_wdata_o  (reg_wdata_o),
      .fifo_cnt_o   (fifo_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
      pipe_we_i    = we;
      pipe_waddr_i = a;
      pipe_wdata_i = d;
   endtask

   task automatic mc(input logic v, input logic [4:0] a, input logic [31:0] d);
      mc_valid_i = v;
      mc_waddr_i = a;
      mc_wdata_i = d;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_we"},   32'(reg_we_o),    32'(we));
      chk({tag, "_addr"}, 32'(reg_waddr_o), 32'(a));
      chk({tag, "_data"}, reg_wdata_o,      d);
   endtask

   initial begin
      rst = 1'b0;
      pipe(1'b0, 5'd0, 32'h0);
      mc(1'b0, 5'd0, 32'h0);
      #12;
      chk_wr("rst", 1'b0, 5'd0, 32'h0);
      chk("rst_cnt",   32'(fifo_cnt_o),   32'd0);
      chk("rst_ready", 32'(mc_ready_o),   32'd1);
      chk("rst_stall", 32'(pipe_stall_o), 32'd0);
      rst = 1'b1;
      tick();

      // Plain pipeline write
      pipe(1'b1, 5'd5, 32'hA5A5A5A5);
      tick();
      chk_wr("pipe_wr", 1'b1, 5'd5, 32'hA5A5A5A5);
      pipe(1'b0, 5'd0, 32'h0);
      tick();
      chk_wr("pipe_idle", 1'b0, 5'd0, 32'h0);

      // Single mc write, pipeline idle: written two cycles after acceptance
      mc(1'b1, 5'd7, 32'h11);
      chk("mc_ready0", 32'(mc_ready_o), 32'd1);
      tick();
      mc(1'b0, 5'd0, 32'h0);
      chk("mc_cnt1", 32'(fifo_cnt_o), 32'd1);
      chk("mc_nobypass", 32'(reg_we_o), 32'd0);
      tick();
      chk_wr("mc_wr", 1'b1, 5'd7, 32'h11);
      chk("mc_cnt0", 32'(fifo_cnt_o), 32'd0);
      tick();
      chk("mc_after", 32'(reg_we_o), 32'd0);

      // Fill FIFO while the pipeline writes every cycle
      mc(1'b1, 5'd1, 32'h101);
      pipe(1'b1, 5'd10, 32'h10);
      tick();
      chk_wr("fill_a", 1'b1, 5'd10, 32'h10);
      chk("fill_cnt1", 32'(fifo_cnt_o), 32'd1);
      chk("fill_rdy1", 32'(mc_ready_o), 32'd1);
      mc(1'b1, 5'd2, 32'h102);
      pipe(1'b1, 5'd11, 32'h11);
      tick();
      chk_wr("fill_b", 1'b1, 5'd11, 32'h11);
      chk("fill_cnt2", 32'(fifo_cnt_o), 32'd2);
      chk("fill_rdy2", 32'(mc_ready_o), 32'd0);
      mc(1'b1, 5'd3, 32'h103);
      pipe(1'b1, 5'd12, 32'h12);
      tick();
      chk_wr("fill_c", 1'b1, 5'd12, 32'h12);
      chk("held_cnt", 32'(fifo_cnt_o), 32'd2);
      chk("held_rdy", 32'(mc_ready_o), 32'd0);
      pipe(1'b0, 5'd0, 32'h0);
      tick();
      // Full when the head left: third offer still not taken
      chk_wr("drain_1", 1'b1, 5'd1, 32'h101);
      chk("drain_cnt1", 32'(fifo_cnt_o), 32'd1);
      chk("drain_rdy", 32'(mc_ready_o), 32'd1);
      tick();
      // Enqueue and dequeue together at count 1
      chk_wr("drain_2", 1'b1, 5'd2, 32'h102);
      chk("simul_cnt", 32'(fifo_cnt_o), 32'd1);
      mc(1'b0, 5'd0, 32'h0);
      tick();
      chk_wr("drain_3", 1'b1, 5'd3, 32'h103);
      chk("drain_cnt0", 32'(fifo_cnt_o), 32'd0);

      // Starvation: one pending entry against continuous pipeline writes
      mc(1'b1, 5'd9, 32'h99);
      pipe(1'b1, 5'd20, 32'h200);
      tick();
      mc(1'b0, 5'd0, 32'h0);
      chk_wr("starve_p0", 1'b1, 5'd20, 32'h200);
      for (int i = 1; i <= 4; i++) begin
         chk("starve_nostall", 32'(pipe_stall_o), 32'd0);
         pipe(1'b1, 5'(20 + i), 32'(32'h200 + i));
         tick();
         chk_wr("starve_p", 1'b1, 5'(20 + i), 32'(32'h200 + i));
      end
      chk("starve_stall", 32'(pipe_stall_o), 32'd1);
      pipe(1'b1, 5'd25, 32'h205);
      tick();
      chk_wr("starve_head", 1'b1, 5'd9, 32'h99);
      chk("starve_drop", 32'(pipe_stall_o), 32'd0);
      chk("starve_cnt", 32'(fifo_cnt_o), 32'd0);
      tick();
      chk_wr("starve_repres", 1'b1, 5'd25, 32'h205);
      pipe(1'b0, 5'd0, 32'h0);
      tick();

      // x0 handling
      mc(1'b1, 5'd3, 32'h33);
      tick();
      mc(1'b0, 5'd0, 32'h0);
      pipe(1'b1, 5'd0, 32'hDEAD);
      tick();
      chk_wr("x0_pipe", 1'b1, 5'd3, 32'h33);
      pipe(1'b0, 5'd0, 32'h0);
      mc(1'b1, 5'd0, 32'h44);
      tick();
      mc(1'b0, 5'd0, 32'h0);
      chk("x0_mc_cnt", 32'(fifo_cnt_o), 32'd0);
      chk("x0_mc_we0", 32'(reg_we_o), 32'd0);
      tick();
      chk("x0_mc_we1", 32'(reg_we_o), 32'd0);

      // Reset mid-operation with a full FIFO and a write in flight
      mc(1'b1, 5'd4, 32'h44);
      pipe(1'b1, 5'd12, 32'h12);
      tick();
      mc(1'b1, 5'd5, 32'h55);
      pipe(1'b1, 5'd13, 32'h13);
      tick();
      chk("pre_rst_cnt", 32'(fifo_cnt_o), 32'd2);
      chk_wr("pre_rst", 1'b1, 5'd13, 32'h13);
      mc(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      chk_wr("async_rst", 1'b0, 5'd0, 32'h0);
      chk("async_cnt",   32'(fifo_cnt_o),   32'd0);
      chk("async_ready", 32'(mc_ready_o),   32'd1);
      chk("async_stall", 32'(pipe_stall_o), 32'd0);
      tick();
      #2;
      rst = 1'b1;
      tick();
      chk("post_rst_we0", 32'(reg_we_o), 32'd0);
      tick();
      chk("post_rst_we1", 32'(reg_we_o), 32'd0);
      chk("post_rst_cnt", 32'(fifo_cnt_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
